mem_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave arbiter for the matrix-multiplier memory bus, using the existing req/ack/w_en/addr handshake. It generalises the single-channel memory link to NUM_MASTERS channels, splits the shared bidirectional data bus into separate write and read data paths, and adds round-robin fairness and a slave-ack timeout with error reporting. It sits between the compute/load engines (masters) and one memory controller (slave).

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/mem_rr_arbiter_rr_pick.sv | 30 +++
 rtl/mem_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_rr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the matrix-multiplier memory bus: handshake FSM states
// and default bus widths used by the arbiter and future memory-side blocks.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } bus_state_e;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 256;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request at or
// after rr_ptr, searching cyclically, plus a flag saying any request was found.
module rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       grant,
  output logic                   valid
);

  int unsigned idx;

  // NOTE: every output gets a default before the search loop so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_MASTERS;
      if (!valid && req[idx]) begin
        grant = IDX_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// N-master to 1-slave round-robin arbiter for the memory bus, with split
// read/write data paths and a slave-ack timeout reported through m_err.
module mem_rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT     = 64,
  parameter int TMR_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_w_en,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_w_en,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

  bus_state_e       state, state_nxt;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [TMR_W-1:0] timer;
  logic             ack_hit;
  logic             timeout_hit;
  logic [IDX_W-1:0] ptr_after_grant;

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_rr_pick (
    .req   (m_req),
    .rr_ptr(rr_ptr),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  // A slave ack in the expiry cycle takes precedence over the timeout.
  assign ack_hit         = (state == BUSY) && s_ack;
  assign timeout_hit     = (TIMEOUT != 0) && (state == BUSY) && !s_ack && (timer == TMR_LAST);
  assign ptr_after_grant = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = BUSY;
      BUSY:    if (ack_hit || timeout_hit) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the wide data registers are reset too, because every output must
  // read zero while reset_n is low; nothing here is a RAM array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q <= '0;
      rr_ptr  <= '0;
      timer   <= '0;
      m_ack   <= '0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      s_req   <= 1'b0;
      s_w_en  <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            s_w_en  <= m_w_en[pick_idx];
            s_addr  <= m_addr[pick_idx*ADDR_W +: ADDR_W];
            s_wdata <= m_wdata[pick_idx*DATA_W +: DATA_W];
            s_req   <= 1'b1;
            timer   <= '0;
          end
        end
        BUSY: begin
          timer <= timer + 1'b1;
          if (ack_hit) begin
            s_req          <= 1'b0;
            m_rdata        <= s_rdata;
            m_ack[grant_q] <= 1'b1;
            m_err          <= 1'b0;
            rr_ptr         <= ptr_after_grant;
          end else if (timeout_hit) begin
            s_req          <= 1'b0;
            m_ack[grant_q] <= 1'b1;
            m_err          <= 1'b1;
            rr_ptr         <= ptr_after_grant;
          end
        end
        ACK: begin
          m_ack <= '0;
          m_err <= 1'b0;
        end
        default: begin
          m_ack <= '0;
          m_err <= 1'b0;
          s_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: table-driven vectors for the rr_pick
// selector plus hand-written multi-cycle sequences for the arbiter.
module tb_mem_rr_arbiter;
  import mem_bus_pkg::*;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 256;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NM-1:0]        m_req;
  logic [NM-1:0]        m_w_en;
  logic [NM*AW-1:0]     m_addr;
  logic [NM*DW-1:0]     m_wdata;
  logic [NM-1:0]        m_ack;
  logic                 m_err;
  logic [DW-1:0]        m_rdata;
  logic                 s_req;
  logic                 s_w_en;
  logic [AW-1:0]        s_addr;
  logic [DW-1:0]        s_wdata;
  logic                 s_ack;
  logic [DW-1:0]        s_rdata;

  logic [3:0] p_req;
  logic [1:0] p_ptr;
  logic [1:0] p_grant;
  logic       p_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8), .TMR_W(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .m_req  (m_req),
    .m_w_en (m_w_en),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_ack  (m_ack),
    .m_err  (m_err),
    .m_rdata(m_rdata),
    .s_req  (s_req),
    .s_w_en (s_w_en),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_ack  (s_ack),
    .s_rdata(s_rdata)
  );

  rr_pick #(.NUM_MASTERS(4), .IDX_W(2)) u_pick (
    .req   (p_req),
    .rr_ptr(p_ptr),
    .grant (p_grant),
    .valid (p_valid)
  );

  // Masters must hold m_req until their ack.
  always @(negedge clk) begin
    if (reset_n && dut.state == BUSY && !m_req[dut.grant_q])
      $error("protocol: granted master dropped m_req during BUSY");
  end

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [1:0] exp_grant;
    logic       exp_valid;
  } pick_vec_t;

  pick_vec_t pick_tbl [9];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_w_en[i]          = w;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_ack"},   DW'(m_ack), '0);
    check({tag, "_m_err"},   DW'(m_err), '0);
    check({tag, "_m_rdata"}, m_rdata, '0);
    check({tag, "_s_req"},   DW'(s_req), '0);
    check({tag, "_s_w_en"},  DW'(s_w_en), '0);
    check({tag, "_s_addr"},  DW'(s_addr), '0);
    check({tag, "_s_wdata"}, s_wdata, '0);
  endtask

  initial begin
    int n;
    int cnt;
    int order [6];

    pick_tbl[0] = '{4'b0000, 2'd0, 2'd0, 1'b0};
    pick_tbl[1] = '{4'b0001, 2'd0, 2'd0, 1'b1};
    pick_tbl[2] = '{4'b1111, 2'd0, 2'd0, 1'b1};
    pick_tbl[3] = '{4'b1111, 2'd2, 2'd2, 1'b1};
    pick_tbl[4] = '{4'b1000, 2'd0, 2'd3, 1'b1};
    pick_tbl[5] = '{4'b0001, 2'd3, 2'd0, 1'b1};
    pick_tbl[6] = '{4'b0110, 2'd3, 2'd1, 1'b1};
    pick_tbl[7] = '{4'b1010, 2'd2, 2'd3, 1'b1};
    pick_tbl[8] = '{4'b0100, 2'd3, 2'd2, 1'b1};
    order = '{0, 1, 2, 3, 0, 1};

    reset_n = 1'b0;
    m_req   = '0;
    m_w_en  = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    p_req   = '0;
    p_ptr   = '0;

    // rr_pick standalone vectors
    for (int i = 0; i < 9; i++) begin
      p_req = pick_tbl[i].req;
      p_ptr = pick_tbl[i].ptr;
      #1;
      check($sformatf("pick%0d_valid", i), DW'(p_valid), DW'(pick_tbl[i].exp_valid));
      if (pick_tbl[i].exp_valid)
        check($sformatf("pick%0d_grant", i), DW'(p_grant), DW'(pick_tbl[i].exp_grant));
    end

    // Reset state
    #1;
    check_all_zero("reset");
    step();
    step();
    reset_n = 1'b1;

    // Round-robin with all masters requesting and an immediate-ack slave
    for (int i = 0; i < NM; i++) set_master(i, 1'b0, AW'(16'h0100 + i), '0);
    m_req = 4'hF;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      step();
      if (m_ack != 0) begin
        check($sformatf("rr_ack%0d", n), DW'(m_ack), DW'(4'b0001 << order[n]));
        check($sformatf("rr_rdata%0d", n), m_rdata, DW'(16'h0100 + order[n]));
        check($sformatf("rr_err%0d", n), DW'(m_err), '0);
        n++;
        if (n == 6) m_req = '0;
      end
      s_ack   = s_req;
      s_rdata = s_req ? DW'(s_addr) : '0;
    end
    check("rr_count", DW'(n), DW'(6));
    s_ack = 1'b0;
    step();

    // Single read on master 2, slave acks 3 cycles after s_req
    set_master(2, 1'b0, 16'h0040, '0);
    m_req = 4'b0100;
    step();
    check("rd_s_req", DW'(s_req), DW'(1));
    check("rd_s_addr", DW'(s_addr), DW'(16'h0040));
    check("rd_s_w_en", DW'(s_w_en), '0);
    step();
    step();
    step();
    check("rd_s_req_held", DW'(s_req), DW'(1));
    check("rd_no_early_ack", DW'(m_ack), '0);
    s_ack   = 1'b1;
    s_rdata = DW'(8'hA5);
    step();
    s_ack = 1'b0;
    check("rd_m_ack", DW'(m_ack), DW'(4'b0100));
    check("rd_m_rdata", m_rdata, DW'(8'hA5));
    check("rd_m_err", DW'(m_err), '0);
    check("rd_s_req_low", DW'(s_req), '0);
    m_req = '0;
    step();
    check("rd_ack_pulse", DW'(m_ack), '0);

    // Write pass-through on master 0
    set_master(0, 1'b1, 16'h1234, DW'(16'hDEAD));
    m_req = 4'b0001;
    step();
    check("wr_s_req", DW'(s_req), DW'(1));
    check("wr_s_w_en", DW'(s_w_en), DW'(1));
    check("wr_s_addr", DW'(s_addr), DW'(16'h1234));
    check("wr_s_wdata", s_wdata, DW'(16'hDEAD));
    step();
    check("wr_s_wdata_held", s_wdata, DW'(16'hDEAD));
    check("wr_s_req_held", DW'(s_req), DW'(1));
    s_ack   = 1'b1;
    s_rdata = DW'(8'h77);
    step();
    s_ack = 1'b0;
    check("wr_m_ack", DW'(m_ack), DW'(4'b0001));
    check("wr_m_rdata", m_rdata, DW'(8'h77));
    m_req = '0;
    step();
    check("wr_ack_pulse", DW'(m_ack), '0);

    // Timeout on master 1: the slave never acks
    set_master(1, 1'b0, 16'h0011, '0);
    m_req = 4'b0010;
    step();
    cnt = 0;
    while (s_req && cnt < 20) begin
      cnt++;
      step();
    end
    check("to_s_req_cycles", DW'(cnt), DW'(8));
    check("to_m_ack", DW'(m_ack), DW'(4'b0010));
    check("to_m_err", DW'(m_err), DW'(1));
    check("to_m_rdata_kept", m_rdata, DW'(8'h77));
    m_req = '0;
    step();
    check("to_err_pulse", DW'(m_err), '0);
    s_ack   = 1'b1;
    s_rdata = DW'(8'hFF);
    step();
    check("stray_s_req", DW'(s_req), '0);
    check("stray_m_ack", DW'(m_ack), '0);
    step();
    check("stray_m_ack2", DW'(m_ack), '0);
    check("stray_m_rdata", m_rdata, DW'(8'h77));
    s_ack = 1'b0;

    // Normal transaction after the timeout
    set_master(3, 1'b0, 16'h0300, '0);
    m_req = 4'b1000;
    step();
    check("post_s_req", DW'(s_req), DW'(1));
    check("post_s_addr", DW'(s_addr), DW'(16'h0300));
    s_ack   = 1'b1;
    s_rdata = DW'(8'h33);
    step();
    s_ack = 1'b0;
    check("post_m_ack", DW'(m_ack), DW'(4'b1000));
    check("post_m_err", DW'(m_err), '0);
    check("post_m_rdata", m_rdata, DW'(8'h33));
    m_req = '0;
    step();

    // Ack arriving in the expiry cycle wins
    set_master(1, 1'b0, 16'h0111, '0);
    m_req = 4'b0010;
    step();
    for (int i = 0; i < 7; i++) step();
    check("exp_s_req_last", DW'(s_req), DW'(1));
    s_ack   = 1'b1;
    s_rdata = DW'(16'hBEEF);
    step();
    s_ack = 1'b0;
    check("exp_m_ack", DW'(m_ack), DW'(4'b0010));
    check("exp_m_err", DW'(m_err), '0);
    check("exp_m_rdata", m_rdata, DW'(16'hBEEF));
    m_req = '0;
    step();

    // Asynchronous reset in the middle of a transaction
    set_master(2, 1'b1, 16'h0222, DW'(16'h5555));
    m_req = 4'b0100;
    step();
    check("mid_s_req", DW'(s_req), DW'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    m_req = 4'b1000;
    set_master(3, 1'b0, 16'h0333, '0);
    step();
    reset_n = 1'b1;
    check("mid_rst_no_ack", DW'(m_ack), '0);
    step();
    check("rel_s_req", DW'(s_req), DW'(1));
    check("rel_s_addr", DW'(s_addr), DW'(16'h0333));
    s_ack   = 1'b1;
    s_rdata = DW'(8'h44);
    step();
    s_ack = 1'b0;
    check("rel_m_ack", DW'(m_ack), DW'(4'b1000));
    m_req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
